step_to_angle: RTL

- Receive-side counterpart of the step generator: consumes an external STEP/DIR pulse stream and reconstructs absolute position in steps, angle, and step period.
- Used to close the loop on a step generator or to monitor a foreign driver.
- Fixed-point outputs are Q(SIZE/2).(SIZE/2), matching the step generator, so positions and angles can be compared directly.

---
 rtl/step_to_angle.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/step_to_angle.sv
// step_to_angle: decodes an external STEP/DIR pulse stream into a Q-format
// position, a scaled angle and the period between steps in microseconds.
module step_to_angle #(
  parameter int unsigned     SIZE           = 64,
  parameter logic [SIZE-1:0] SCALE_INV      = 64'h0000_0000_0010_624E,
  parameter int unsigned     SYSCLK         = 25000000,
  parameter int unsigned     SYNC_STAGES    = 2,
  parameter int unsigned     MIN_PULSE_CLKS = 2,
  parameter int unsigned     TIMEOUT_US     = 100000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            enable_in,
  input  logic            clear_in,
  input  logic            step_in,
  input  logic            dir_in,
  output logic [SIZE-1:0] position_out,
  output logic [SIZE-1:0] angle_out,
  output logic            angle_valid_out,
  output logic [31:0]     period_us_out,
  output logic            moving_out,
  output logic            overflow_out
);

  localparam int unsigned SF        = SIZE / 2;
  localparam int unsigned TICK_CLKS = SYSCLK / 1000000;
  localparam int unsigned TICK_W    = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int unsigned FILT_W    = $clog2(MIN_PULSE_CLKS + 1);
  localparam int unsigned US_W      = 32;
  localparam logic [SIZE:0] INC     = (SIZE + 1)'(1) << SF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TRACKING,
    S_STALLED
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [SYNC_STAGES-1:0]  r_step_sync;
  logic [SYNC_STAGES-1:0]  r_dir_sync;
  logic [FILT_W-1:0]       r_filt_cnt;
  logic                    r_step_filt;
  logic                    r_step_filt_d;
  logic [TICK_W-1:0]       r_tick_cnt;
  logic [US_W-1:0]         r_us_cnt;
  logic [SIZE-1:0]         r_position;
  logic [SIZE-1:0]         r_angle;
  logic [31:0]             r_period;
  logic                    r_moving;
  logic                    r_overflow;
  logic                    r_valid_s0;
  logic                    r_valid_s1;
  logic                    r_angle_valid;
  logic signed [2*SIZE-1:0] r_product;

  logic                    w_step_s;
  logic                    w_dir_s;
  logic                    w_event;
  logic                    w_tick;
  logic                    w_accept;
  logic                    w_latch_period;
  logic                    w_zero_period;
  logic [SIZE:0]           w_pos_ext;
  logic [SIZE:0]           w_pos_sum;
  logic                    w_pos_ovf;
  logic signed [2*SIZE-1:0] w_pos_wide;
  logic signed [2*SIZE-1:0] w_scale_wide;
  logic signed [2*SIZE-1:0] w_product;
  logic                    w_prod_unused;

  assign w_step_s = r_step_sync[SYNC_STAGES-1];
  assign w_dir_s  = r_dir_sync[SYNC_STAGES-1];
  assign w_event  = r_step_filt & ~r_step_filt_d;
  assign w_tick   = (r_tick_cnt == TICK_W'(TICK_CLKS - 1));

  // Input synchronizers and glitch filter on the step level
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_step_sync   <= '0;
      r_dir_sync    <= '0;
      r_filt_cnt    <= '0;
      r_step_filt   <= 1'b0;
      r_step_filt_d <= 1'b0;
    end else begin
      r_step_sync   <= {r_step_sync[SYNC_STAGES-2:0], step_in};
      r_dir_sync    <= {r_dir_sync[SYNC_STAGES-2:0], dir_in};
      r_step_filt_d <= r_step_filt;
      if (w_step_s != r_step_filt) begin
        if (r_filt_cnt == FILT_W'(MIN_PULSE_CLKS - 1)) begin
          r_step_filt <= w_step_s;
          r_filt_cnt  <= '0;
        end else begin
          r_filt_cnt  <= r_filt_cnt + FILT_W'(1);
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  // Microsecond prescaler and saturating inter-step counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tick_cnt <= '0;
      r_us_cnt   <= '0;
    end else begin
      if (clear_in || w_tick) r_tick_cnt <= '0;
      else                    r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      if (clear_in || w_accept)
        r_us_cnt <= '0;
      else if (w_tick && (r_us_cnt != US_W'(TIMEOUT_US)))
        r_us_cnt <= r_us_cnt + US_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and per-event control; clear beats a same-cycle event
  always_comb begin
    w_next_state   = r_state;
    w_accept       = 1'b0;
    w_latch_period = 1'b0;
    w_zero_period  = 1'b0;
    if (clear_in) begin
      w_next_state = enable_in ? S_ARMED : S_IDLE;
    end else if (!enable_in) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next_state = S_ARMED;
        S_ARMED, S_STALLED: begin
          if (w_event) begin
            w_accept      = 1'b1;
            w_zero_period = 1'b1;
            w_next_state  = S_TRACKING;
          end
        end
        S_TRACKING: begin
          if (w_event) begin
            w_accept       = 1'b1;
            w_latch_period = 1'b1;
          end else if (r_us_cnt == US_W'(TIMEOUT_US)) begin
            w_zero_period = 1'b1;
            w_next_state  = S_STALLED;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  assign w_pos_ext = {r_position[SIZE-1], r_position};
  assign w_pos_sum = w_dir_s ? (w_pos_ext + INC) : (w_pos_ext - INC);
  assign w_pos_ovf = w_pos_sum[SIZE] ^ w_pos_sum[SIZE-1];

  // Position, period, status flags and pipeline entry
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_position <= '0;
      r_overflow <= 1'b0;
      r_period   <= '0;
      r_moving   <= 1'b0;
      r_valid_s0 <= 1'b0;
    end else begin
      r_moving <= (w_next_state == S_TRACKING);
      if (clear_in) begin
        r_position <= '0;
        r_overflow <= 1'b0;
        r_valid_s0 <= 1'b1;
      end else if (w_accept && w_pos_ovf) begin
        r_overflow <= 1'b1;
        r_valid_s0 <= 1'b0;
      end else if (w_accept) begin
        r_position <= w_pos_sum[SIZE-1:0];
        r_valid_s0 <= 1'b1;
      end else begin
        r_valid_s0 <= 1'b0;
      end
      if (clear_in || w_zero_period) r_period <= '0;
      else if (w_latch_period)       r_period <= r_us_cnt;
    end
  end

  assign w_pos_wide    = {{SIZE{r_position[SIZE-1]}}, r_position};
  assign w_scale_wide  = {{SIZE{SCALE_INV[SIZE-1]}}, SCALE_INV};
  assign w_product     = w_pos_wide * w_scale_wide;
  assign w_prod_unused = ^{r_product[2*SIZE-1:SF+SIZE], r_product[SF-1:0]};

  // Two-stage angle pipeline; slicing the product floors toward -inf
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_product     <= '0;
      r_valid_s1    <= 1'b0;
      r_angle       <= '0;
      r_angle_valid <= 1'b0;
    end else if (clear_in) begin
      r_product     <= '0;
      r_valid_s1    <= 1'b0;
      r_angle       <= '0;
      r_angle_valid <= 1'b0;
    end else begin
      r_product     <= w_product;
      r_valid_s1    <= r_valid_s0;
      r_angle_valid <= r_valid_s1;
      if (r_valid_s1) r_angle <= r_product[SF +: SIZE];
    end
  end

  assign position_out    = r_position;
  assign angle_out       = r_angle;
  assign angle_valid_out = r_angle_valid;
  assign period_us_out   = r_period;
  assign moving_out      = r_moving;
  assign overflow_out    = r_overflow;

endmodule
